// File: rtl/pin_capture_pkg.sv
// rtl/pin_capture_pkg.sv - shared state encoding and key/PIN constants for pin_capture
package pin_capture_pkg;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    DIGITO1  = 2'd1,
    COMPLETO = 2'd2,
    PRESENTA = 2'd3
  } state_t;

  localparam logic [3:0] TECLA_BORRAR = 4'hA;
  localparam logic [3:0] TECLA_ENTER  = 4'hB;
  localparam logic [7:0] PIN_ESPERA   = 8'h00;

  function automatic logic es_digito(input logic [3:0] t);
    return t <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_capture_if.sv
// rtl/pin_capture_if.sv - keypad input and PIN output bundle between keypad, pin_capture and gate controller
interface pin_capture_if;
  logic       Tecla_valida;
  logic [3:0] Tecla;
  logic [7:0] Pin;
  logic       Ocupado;
  logic       Error;

  modport master (output Tecla_valida, output Tecla, input Pin, input Ocupado, input Error);
  modport slave  (input Tecla_valida, input Tecla, output Pin, output Ocupado, output Error);
endinterface

// File: rtl/pin_capture_key_edge_detect.sv
// rtl/pin_capture_key_edge_detect.sv - key_edge_detect: one pulse per rising edge of a debounced key level
module key_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic pulse
);
  logic prev;

  always_ff @(posedge Clk) begin
    if (!Reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;
endmodule

// File: rtl/pin_capture.sv
// rtl/pin_capture.sv - assembles a 2-digit BCD PIN from keypad events and presents it on Pin
// Optional partial-entry timeout enabled by defining PIN_CAPTURE_TIMEOUT_EN.
module pin_capture
  import pin_capture_pkg::*;
#(
  parameter int PIN_HOLD = 1,
  parameter int TIMEOUT  = 1000,
  parameter int TW       = 10
) (
  input logic          Clk,
  input logic          Reset,
  pin_capture_if.slave bus
);
  localparam int CNT_MAX = (TIMEOUT > PIN_HOLD) ? TIMEOUT : PIN_HOLD;

  state_t        state_q, state_d;
  logic [3:0]    d1_q, d1_d, d2_q, d2_d;
  logic [7:0]    pin_q, pin_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q;
  logic          cnt_clr, ev, timeout_hit, digit, illegal;

  key_edge_detect u_edge (.Clk(Clk), .Reset(Reset), .level(bus.Tecla_valida), .pulse(ev));

  assign digit   = es_digito(bus.Tecla);
  assign illegal = bus.Tecla > TECLA_ENTER;

`ifdef PIN_CAPTURE_TIMEOUT_EN
  assign timeout_hit = (cnt_q == TW'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    pin_d   = pin_q;
    err_d   = 1'b0;
    case (state_q)
      ESPERA: begin
        if (ev) begin
          if (digit) begin
            d1_d    = bus.Tecla;
            state_d = DIGITO1;
          end else if (bus.Tecla != TECLA_BORRAR) begin
            err_d = 1'b1;
          end
        end
      end
      DIGITO1: begin
        if (ev) begin
          if (digit) begin
            d2_d    = bus.Tecla;
            state_d = COMPLETO;
          end else if (bus.Tecla == TECLA_BORRAR) begin
            state_d = ESPERA;
          end else begin
            err_d = 1'b1;
            if (!illegal) state_d = ESPERA;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ESPERA;
        end
      end
      COMPLETO: begin
        if (ev) begin
          if (bus.Tecla == TECLA_ENTER) begin
            // "00" is indistinguishable from the idle bus value, so it is never presented
            if ({d1_q, d2_q} == PIN_ESPERA) begin
              err_d   = 1'b1;
              state_d = ESPERA;
            end else begin
              pin_d   = {d1_q, d2_q};
              state_d = PRESENTA;
            end
          end else if (bus.Tecla == TECLA_BORRAR) begin
            state_d = ESPERA;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ESPERA;
        end
      end
      PRESENTA: begin
        if (cnt_q == TW'(PIN_HOLD - 1)) begin
          pin_d   = PIN_ESPERA;
          state_d = ESPERA;
        end
      end
      default: state_d = ESPERA;
    endcase
    if (state_d == ESPERA) begin
      d1_d = 4'd0;
      d2_d = 4'd0;
    end
    cnt_clr = (ev && (state_q != PRESENTA) && !err_d) ||
              ((state_d == PRESENTA) && (state_q != PRESENTA));
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ESPERA;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      pin_q   <= PIN_ESPERA;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      pin_q   <= pin_d;
      err_q   <= err_d;
      if (cnt_clr)                    cnt_q <= '0;
      else if (cnt_q != TW'(CNT_MAX)) cnt_q <= cnt_q + TW'(1);
    end
  end

  assign bus.Pin     = pin_q;
  assign bus.Ocupado = (state_q != ESPERA);
  assign bus.Error   = err_q;
endmodule

// File: tb/tb_pin_capture.sv
// tb/tb_pin_capture.sv - self-checking bench for pin_capture against a key-sequence reference model
module tb_pin_capture;
  import pin_capture_pkg::*;

  localparam int HOLD = 2;
  localparam int TMO  = 16;
  localparam int TWB  = 10;
`ifdef PIN_CAPTURE_TIMEOUT_EN
  localparam int LONG = 12;
`else
  localparam int LONG = 20;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  pin_capture_if bus();

  pin_capture #(.PIN_HOLD(HOLD), .TIMEOUT(TMO), .TW(TWB)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  int compared = 0;
  int mismatched = 0;

  // observed traffic
  bit         mon_en = 1'b0;
  logic [7:0] pin_prev = 8'h00;
  int         err_seen = 0;
  logic [7:0] pins[$];
  int         runs[$];

  // reference model state
  logic [3:0] ebuf[$];
  logic [7:0] exp_pins[$];
  int         exp_err = 0;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (bus.Error === 1'b1) err_seen++;
      if (bus.Pin !== 8'h00) begin
        if (pin_prev === 8'h00) begin
          pins.push_back(bus.Pin);
          runs.push_back(1);
        end else begin
          runs[runs.size()-1]++;
        end
      end
      pin_prev = bus.Pin;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key-level rules: two digits then ENTER yields a PIN, anything out of order is an error.
  task automatic apply_key(input logic [3:0] k);
    if (k > 4'hB) exp_err++;
    else if (k == 4'hA) ebuf.delete();
    else if (k == 4'hB) begin
      if (ebuf.size() == 2) begin
        if (ebuf[0] == 4'd0 && ebuf[1] == 4'd0) exp_err++;
        else exp_pins.push_back({ebuf[0], ebuf[1]});
      end else begin
        exp_err++;
      end
      ebuf.delete();
    end else if (ebuf.size() < 2) ebuf.push_back(k);
    else exp_err++;
  endtask

  task automatic press(input logic [3:0] k, input int hi, input int lo, input bit model);
    bus.Tecla = k;
    bus.Tecla_valida = 1'b1;
    if (model) apply_key(k);
    repeat (hi) @(negedge Clk);
    bus.Tecla_valida = 1'b0;
    bus.Tecla = 4'($urandom);
    repeat (lo) @(negedge Clk);
  endtask

  task automatic verify(input string tag);
    repeat (HOLD + 2) @(negedge Clk);
    check($sformatf("%s_npins", tag), pins.size(), exp_pins.size());
    for (int i = 0; i < pins.size() && i < exp_pins.size(); i++) begin
      check($sformatf("%s_pin%0d", tag, i), pins[i], exp_pins[i]);
      check($sformatf("%s_hold%0d", tag, i), runs[i], HOLD);
    end
    check($sformatf("%s_errors", tag), err_seen, exp_err);
    pins.delete();
    runs.delete();
    exp_pins.delete();
    err_seen = 0;
    exp_err = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [3:0] k;
    bus.Tecla_valida = 1'b0;
    bus.Tecla = 4'h0;
    repeat (3) @(negedge Clk);
    check("reset_pin", bus.Pin, 8'h00);
    check("reset_ocupado", bus.Ocupado, 1'b0);
    check("reset_error", bus.Error, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    mon_en = 1'b1;

    // 0, 8, ENTER with exact presentation timing
    press(4'h0, 3, 2, 1'b1);
    press(4'h8, 3, 2, 1'b1);
    bus.Tecla = TECLA_ENTER;
    bus.Tecla_valida = 1'b1;
    apply_key(TECLA_ENTER);
    @(negedge Clk);
    for (int i = 0; i < HOLD; i++) begin
      check("t1_pin", bus.Pin, 8'h08);
      check("t1_ocupado", bus.Ocupado, 1'b1);
      @(negedge Clk);
    end
    check("t1_pin_rest", bus.Pin, 8'h00);
    check("t1_ocupado_rest", bus.Ocupado, 1'b0);
    bus.Tecla_valida = 1'b0;
    repeat (2) @(negedge Clk);
    verify("t1");

    // BORRAR discards a complete entry
    press(4'h1, 3, 2, 1'b1);
    press(4'h2, 3, 2, 1'b1);
    press(TECLA_BORRAR, 3, 2, 1'b1);
    press(4'h3, 3, 2, 1'b1);
    press(4'h4, 3, 2, 1'b1);
    press(TECLA_ENTER, 3, HOLD + 1, 1'b1);
    verify("t2");

    // ENTER from idle, then the reserved "00"
    bus.Tecla = TECLA_ENTER;
    bus.Tecla_valida = 1'b1;
    apply_key(TECLA_ENTER);
    @(negedge Clk);
    check("t3_err_pulse", bus.Error, 1'b1);
    check("t3_err_pin", bus.Pin, 8'h00);
    @(negedge Clk);
    check("t3_err_clear", bus.Error, 1'b0);
    @(negedge Clk);
    bus.Tecla_valida = 1'b0;
    repeat (2) @(negedge Clk);
    press(4'h0, 2, 2, 1'b1);
    press(4'h0, 2, 2, 1'b1);
    press(TECLA_ENTER, 2, HOLD + 1, 1'b1);
    check("t3_00_ocupado", bus.Ocupado, 1'b0);
    verify("t3");

    // third digit rejected; key during presentation ignored
    press(4'h9, 2, 2, 1'b1);
    press(4'h9, 2, 2, 1'b1);
    press(4'h5, 2, 2, 1'b1);
    press(TECLA_ENTER, 1, 1, 1'b1);
    press(4'hE, 1, HOLD + 2, 1'b0);
    verify("t4");

    // a long-held key is a single event
    press(4'h7, LONG, 2, 1'b1);
    press(TECLA_ENTER, 2, 2, 1'b1);
    press(4'h7, LONG, 2, 1'b1);
    press(4'h3, 2, 2, 1'b1);
    press(TECLA_ENTER, 2, HOLD + 1, 1'b1);
    verify("t5");

`ifdef PIN_CAPTURE_TIMEOUT_EN
    bus.Tecla = 4'h5;
    bus.Tecla_valida = 1'b1;
    @(negedge Clk);
    bus.Tecla_valida = 1'b0;
    n = 0;
    while (bus.Error !== 1'b1 && n < TMO + 5) begin
      @(negedge Clk);
      n++;
    end
    exp_err++;
    ebuf.delete();
    check("t6_timeout_fired", bus.Error, 1'b1);
    check("t6_timeout_window", (n >= TMO && n <= TMO + 1), 1'b1);
    check("t6_timeout_ocupado", bus.Ocupado, 1'b0);
    @(negedge Clk);
    check("t6_timeout_err_clear", bus.Error, 1'b0);
    verify("t6");
`else
    press(4'h5, 1, TMO * 3, 1'b1);
    check("t6_no_timeout_ocupado", bus.Ocupado, 1'b1);
    press(4'h6, 2, 2, 1'b1);
    press(TECLA_ENTER, 2, HOLD + 1, 1'b1);
    verify("t6");
`endif

    // reset during presentation suppresses the rest of the output
    press(4'h4, 2, 2, 1'b1);
    press(4'h2, 2, 2, 1'b1);
    verify("t7_pre");
    mon_en = 1'b0;
    bus.Tecla = TECLA_ENTER;
    bus.Tecla_valida = 1'b1;
    @(negedge Clk);
    check("t7_pin_before_reset", bus.Pin, 8'h42);
    Reset = 1'b0;
    bus.Tecla_valida = 1'b0;
    @(negedge Clk);
    check("t7_pin_after_reset", bus.Pin, 8'h00);
    check("t7_ocupado_after_reset", bus.Ocupado, 1'b0);
    Reset = 1'b1;
    ebuf.delete();
    pin_prev = 8'h00;
    @(negedge Clk);
    mon_en = 1'b1;
    press(4'h1, 2, 2, 1'b1);
    press(4'h5, 2, 2, 1'b1);
    press(TECLA_ENTER, 2, HOLD + 1, 1'b1);
    verify("t7");

    // randomized key streams against the model
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      k = 4'h0;
      else if (r < 60) k = 4'($urandom_range(1, 9));
      else if (r < 72) k = TECLA_BORRAR;
      else if (r < 90) k = TECLA_ENTER;
      else             k = 4'($urandom_range(12, 15));
      press(k, $urandom_range(1, 3),
            $urandom_range(1, 3) + ((k == TECLA_ENTER) ? HOLD : 0), 1'b1);
    end
    verify("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
